// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready pipeline stage with 2-entry skid, flush and
//            optional stall counter (enabled by macro PIPE_STAGE_PERF_EN).
// Revision : 1.0
// ============================================================================
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  head_data_q, head_data_d;
  logic [CTRL_W-1:0]  head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic               in_fire;
  logic               out_fire;

  // Handshake outputs come from registered state only.
  assign in_ready_o  = (state_q != S_SKID);
  assign out_valid_o = (state_q != S_EMPTY);
  assign out_data_o  = head_data_q;
  assign out_ctrl_o  = out_valid_o ? head_ctrl_q : '0;
  assign occupancy_o = state_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d     = S_FULL;
          head_data_d = in_data_i;
          head_ctrl_d = in_ctrl_i;
        end
      end
      S_FULL: begin
        if (in_fire && out_fire) begin
          head_data_d = in_data_i;
          head_ctrl_d = in_ctrl_i;
        end else if (in_fire) begin
          state_d     = S_SKID;
          skid_data_d = in_data_i;
          skid_ctrl_d = in_ctrl_i;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_SKID: begin
        if (out_fire) begin
          state_d     = S_FULL;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush invalidates everything; payload registers simply keep their value.
    if (flush_i) begin
      state_d     = S_EMPTY;
      head_data_d = head_data_q;
      head_ctrl_d = head_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
  logic [PERF_W-1:0] stall_q;

  // Saturating count of stalled output cycles; flush does not touch it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + PERF_ONE;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Testbench for pipe_stage_skid: directed scenarios plus a randomized scoreboard run.
module tb_pipe_stage_skid;
  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              flush;
  logic [1:0]        occupancy;
  logic [PERF_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .PERF_W(PERF_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ctrl_o(out_ctrl),
    .flush_i(flush), .occupancy_o(occupancy), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(8'h11 + i);
      in_ctrl  = CTRL_W'(16'h0100 + i);
      tick();
      exp = DATA_W'(8'h11 + i);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid beat=%0d got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp) begin failures++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i, out_data, exp); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", i, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain occ=%0d valid=%b exp 0/0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(8'hA0); in_ctrl = 16'h00A0;
    tick();
    checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL bp_occ1 got=%0d exp=1", occupancy); end
    in_data = DATA_W'(8'hA1); in_ctrl = 16'h00A1;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ2 got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    in_data = DATA_W'(8'hA2); in_ctrl = 16'h00A2;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ_hold got=%0d exp=2", occupancy); end
    checks++; if (out_data !== DATA_W'(8'hA0)) begin failures++; $display("FAIL bp_head_stable got=%h exp=a0", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== DATA_W'(8'hA1) || out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got=%h v=%b exp=a1", out_data, out_valid); end
    tick();
    checks++; if (out_data !== DATA_W'(8'hA2) || out_ctrl !== 16'h00A2) begin failures++; $display("FAIL bp_third got=%h/%h exp=a2/00a2", out_data, out_ctrl); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(8'h55); in_ctrl = 16'hFFFF;
    tick();
    checks++; if (out_ctrl !== 16'hFFFF) begin failures++; $display("FAIL flush_pre_ctrl got=%h exp=ffff", out_ctrl); end
    in_data = DATA_W'(8'h56);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = DATA_W'(8'h77);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== 16'h0000) begin failures++; $display("FAIL flush_ctrl got=%h exp=0000", out_ctrl); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== DATA_W'(8'h55)) begin failures++; $display("FAIL flush_data_hold got=%h exp=55", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_reappear cyc=%0d got=%b exp=0", i, out_valid); end
    end
    in_valid = 1'b1; in_data = DATA_W'(8'h99); in_ctrl = 16'h0099;
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== DATA_W'(8'h99) || out_ctrl !== 16'h0099) begin failures++; $display("FAIL flush_after got=%h/%h exp=99/0099", out_data, out_ctrl); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(8'h31); in_ctrl = 16'h1234;
    tick();
    in_data = DATA_W'(8'h32);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL rstp_pre_occ got=%0d exp=2", occupancy); end
    rst = 1'b1; flush = 1'b1; in_data = DATA_W'(8'h33);
    tick();
    rst = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin failures++; $display("FAIL rstp_state v=%b r=%b occ=%0d exp 0/1/0", out_valid, in_ready, occupancy); end
    checks++; if (out_data !== '0 || out_ctrl !== '0) begin failures++; $display("FAIL rstp_payload got=%h/%h exp=0/0", out_data, out_ctrl); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rstp_stall got=%0d exp=0", stall_cnt); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstp_captured got=%b exp=0", out_valid); end
  endtask

  task automatic test_perf();
    logic [PERF_W-1:0] exp_sat;
`ifdef PIPE_STAGE_PERF_EN
    exp_sat = '1;
`else
    exp_sat = '0;
`endif
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DATA_W'(8'h42); in_ctrl = 16'h0042;
    tick();
    in_valid = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    tick();
    checks++; if (stall_cnt !== PERF_W'(1)) begin failures++; $display("FAIL perf_first got=%0d exp=1", stall_cnt); end
    for (int i = 1; i < 20; i++) tick();
`else
    for (int i = 0; i < 20; i++) tick();
`endif
    checks++; if (stall_cnt !== exp_sat) begin failures++; $display("FAIL perf_sat got=%0d exp=%0d", stall_cnt, exp_sat); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (stall_cnt !== exp_sat) begin failures++; $display("FAIL perf_hold got=%0d exp=%0d", stall_cnt, exp_sat); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] dq[$];
    logic [CTRL_W-1:0] cq[$];
    logic in_fire, out_fire;
    int   bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      checks++;
      if (occupancy !== 2'(dq.size())) begin
        bad++; failures++;
        if (bad < 10) $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", cyc, occupancy, dq.size());
      end else if (dq.size() > 0 && (out_valid !== 1'b1 || out_data !== dq[0] || out_ctrl !== cq[0])) begin
        bad++; failures++;
        if (bad < 10) $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", cyc, out_data, out_ctrl, dq[0], cq[0]);
      end else if (dq.size() == 0 && (out_valid !== 1'b0 || out_ctrl !== '0)) begin
        bad++; failures++;
        if (bad < 10) $display("FAIL rand_idle cyc=%0d valid=%b ctrl=%h exp 0/0", cyc, out_valid, out_ctrl);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_ctrl   = CTRL_W'($urandom_range(1, 16'hFFFF));
      in_fire   = in_valid && (dq.size() < 2);
      out_fire  = out_ready && (dq.size() > 0);
      if (out_fire) begin void'(dq.pop_front()); void'(cq.pop_front()); end
      if (in_fire) begin dq.push_back(in_data); cq.push_back(in_ctrl); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_priority();
    test_perf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
